// File: rtl/decode_dense_pipe.sv
// Elastic DEPTH-stage register between decode and the dense engine: carries the
// decoded instruction fields with valid/ready handshake, bubble collapse, flush and occupancy.
module decode_dense_pipe #(
    parameter int size            = 3,
    parameter int data_size       = 16,
    parameter int act_type_size   = 4,
    parameter int dense_type_size = 4,
    parameter int cost_type_size  = 8,
    parameter int index_size      = 32,
    parameter int DEPTH           = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [act_type_size-1:0]      act_type,
    input  logic [dense_type_size-1:0]    dense_type,
    input  logic [cost_type_size-1:0]     cost_type,
    input  logic [data_size*size-1:0]     w,
    input  logic [data_size*size-1:0]     x,
    input  logic [data_size*size-1:0]     label,
    input  logic [index_size-1:0]         w_layer_index,
    input  logic [index_size-1:0]         w_row_index,
    input  logic                          is_update,
    input  logic                          load_w,
    input  logic                          backprop_cost,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [act_type_size-1:0]      act_type_out,
    output logic [dense_type_size-1:0]    dense_type_out,
    output logic [cost_type_size-1:0]     cost_type_out,
    output logic [data_size*size-1:0]     w_out,
    output logic [data_size*size-1:0]     x_out,
    output logic [data_size*size-1:0]     label_out,
    output logic [index_size-1:0]         w_layer_index_out,
    output logic [index_size-1:0]         w_row_index_out,
    output logic                          is_update_out,
    output logic                          load_w_out,
    output logic                          backprop_cost_out,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);
    localparam int VW = data_size * size;
    localparam int PW = act_type_size + dense_type_size + cost_type_size + 3 * VW + 2 * index_size + 3;
    localparam int OW = $clog2(DEPTH + 1);

    logic [PW-1:0]    in_pay;
    logic [PW-1:0]    pay   [DEPTH];
    logic [PW-1:0]    src_p [DEPTH];
    logic [DEPTH-1:0] v, adv, src_v, v_next;
    logic [OW-1:0]    occ_next;
    logic             carry;
    logic             upd_q, ldw_q, bp_q;

    assign in_pay = {act_type, dense_type, cost_type, w, x, label,
                     w_layer_index, w_row_index, is_update, load_w, backprop_cost};

    // A stage may load when it is empty or its successor is moving on (bubble collapse).
    always_comb begin
        adv   = '0;
        carry = out_ready | ~v[DEPTH-1];
        adv[DEPTH-1] = carry;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            carry  = carry | ~v[k];
            adv[k] = carry;
        end
    end

    assign in_ready = adv[0] & ~flush & ~reset;

    always_comb begin
        src_v    = '0;
        src_v[0] = in_valid & in_ready;
        src_p[0] = in_pay;
        for (int k = 1; k < DEPTH; k++) begin
            src_v[k] = v[k-1];
            src_p[k] = pay[k-1];
        end
        v_next   = '0;
        occ_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_next[k] = adv[k] ? src_v[k] : v[k];
            occ_next  = occ_next + OW'(v_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v         <= '0;
            occupancy <= '0;
            // NOTE: payloads are reset too, so every output reads zero right after reset.
            for (int k = 0; k < DEPTH; k++) pay[k] <= '0;
        end else if (flush) begin
            v         <= '0;
            occupancy <= '0;
        end else begin
            v         <= v_next;
            occupancy <= occ_next;
            for (int k = 0; k < DEPTH; k++)
                if (adv[k] && src_v[k]) pay[k] <= src_p[k];
        end
    end

    assign {act_type_out, dense_type_out, cost_type_out, w_out, x_out, label_out,
            w_layer_index_out, w_row_index_out, upd_q, ldw_q, bp_q} = pay[DEPTH-1];

    assign out_valid         = v[DEPTH-1];
    assign is_update_out     = upd_q & out_valid;
    assign load_w_out        = ldw_q & out_valid;
    assign backprop_cost_out = bp_q & out_valid;

endmodule

// File: doc/decode_dense_pipe.md
Name: decode_dense_pipe

Overview:
- Parametrised, elastic pipeline register between the decode stage and the dense layer engine.
- Carries the decoded instruction fields (activation, dense and cost type, weight row, row indices, control strobes, x, label) through DEPTH stages.
- Adds a valid/ready handshake, bubble collapsing, flush and an occupancy count.
- Replaces the fixed one-cycle free-running decode→dense delay so the dense engine can stall decode without losing instructions.

Parameters:
- size, 3, elements per vector bus (w, x, label)
- data_size, 16, bits per element
- act_type_size, 4, activation type field width
- dense_type_size, 4, dense type field width
- cost_type_size, 8, cost type field width
- index_size, 32, width of w_layer_index / w_row_index
- DEPTH, 2, number of pipeline stages (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all in-flight entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage 0 can accept this cycle
- act_type / dense_type / cost_type  in  act/dense/cost_type_size  decoded type fields
- w, x, label  in  data_size*size each  weight row, input vector, label vector
- w_layer_index, w_row_index  in  index_size each  weight addressing
- is_update, load_w, backprop_cost  in  1 each  control strobes
- out_valid  out  1  last stage holds a valid entry
- out_ready  in  1  dense engine accepts
- act_type_out … label_out  out  same widths as inputs  registered fields of the last stage
- is_update_out, load_w_out, backprop_cost_out  out  1 each  strobes, gated by out_valid
- occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Stage k holds valid bit v[k] and a payload register; stage DEPTH-1 drives the *_out ports.
- Advance rule (combinational, from last stage back):
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1]
  - adv[k] = adv[k+1] | ~v[k]
  - in_ready = adv[0] & ~flush
- Stage k loads from stage k-1, or from the inputs for k=0, when adv[k] is 1:
  - v[k] ← v[k-1] (v[0] ← in_valid & in_ready)
  - payload copied only when the incoming valid is 1; otherwise payload holds and only v clears.
- Handshake:
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - Upstream must hold its fields stable while in_valid & ~in_ready.
  - out fields are stable while out_valid & ~out_ready.
- Latency: an entry accepted at edge N appears on out_valid after edge N+DEPTH-1 when no stall. DEPTH=1 gives a one-cycle register.
- Bubble collapse: an empty stage always accepts, so a stalled tail does not block entries behind a gap.
- Throughput: one entry per cycle with out_ready held at 1.
- Full: all v=1 and out_ready=0 → in_ready=0, no state change.
- Simultaneous out transfer with the pipe full: the whole chain shifts, so in_ready=1 in the same cycle.
- Strobe gating: is_update_out, load_w_out and backprop_cost_out equal the stored bit AND out_valid. They are never 1 while out_valid=0.
- occupancy is the registered popcount of v. It updates each edge, and never exceeds DEPTH.
- flush:
  - At the clock edge all v ← 0 and occupancy ← 0; payload registers hold.
  - During the flush cycle in_ready=0, so no input is accepted.
  - An out transfer in the same cycle still counts for the consumer, since out_valid was 1 before the edge.
- reset (dominates flush):
  - All v, all payloads, every output and occupancy ← 0.
  - in_ready is 0 while reset=1 and 1 on the first cycle after reset deasserts.
  - Reset mid-stream discards all entries with no partial output.
- Arithmetic: no arithmetic on the payload; fields pass bit-exact, no width conversion.

Test Plan:
- DEPTH=2, out_ready=1, drive 4 entries back-to-back (w_row_index 0..3, x={16'h0001,16'h0002,16'h0003}) → out_valid for 4 consecutive cycles starting 1 cycle after the first accept; indices out 0,1,2,3; occupancy peaks at 2.
- DEPTH=2, out_ready=0, in_valid held with 3 entries → 2 accepted, then in_ready=0 and occupancy=2. Raise out_ready → entry 0, then 1, then the third drains in order.
- Gap then stall: entry A, idle cycle, entry B, with out_ready=0 after A reaches the last stage → B collapses into stage 0; occupancy=2; in_ready=0.
- Strobe gating: load_w=1 on an entry followed by an idle input → load_w_out=1 exactly one cycle (out_ready=1), and 0 while out_valid=0.
- flush with occupancy=2 and in_valid=1 in the same cycle → next cycle out_valid=0, occupancy=0, offered entry not accepted (in_ready was 0).
- Assert reset with the pipe full → next cycle all outputs 0, out_valid=0, occupancy=0; first accept after reset deasserts emerges with correct fields.
